// File: rtl/dffram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port DFFRAM (registered read, 1-cycle latency).
// A grant loads stage 1, which drives the RAM. Stage 2 then raises ACK to the owner and returns read data.
module dffram_arbiter #(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int WSIZE = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WSIZE-1:0] WE0,
  input  logic [WSIZE-1:0] WE1,
  input  logic [AW-1:0]    A0,
  input  logic [AW-1:0]    A1,
  input  logic [DW-1:0]    DI0,
  input  logic [DW-1:0]    DI1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             ACK0,
  output logic             ACK1,
  output logic [DW-1:0]    DO0,
  output logic [DW-1:0]    DO1,
  output logic             RAM_EN,
  output logic [WSIZE-1:0] RAM_WE,
  output logic [AW-1:0]    RAM_A,
  output logic [DW-1:0]    RAM_DI,
  input  logic [DW-1:0]    RAM_DO
);

  logic             ptr_q, ptr_d;
  logic             s1Valid_q, s1Valid_d;
  logic             s1Owner_q, s1Owner_d;
  logic [WSIZE-1:0] s1We_q, s1We_d;
  logic [AW-1:0]    s1A_q, s1A_d;
  logic [DW-1:0]    s1Di_q, s1Di_d;
  logic             s2Valid_q;
  logic             s2Owner_q;
  logic             s2Read_q;
  logic [DW-1:0]    do0_q, do0_d;
  logic [DW-1:0]    do1_q, do1_d;
  logic             rdAck0, rdAck1;

  // ptr_q names the last granted port; the other port wins a conflict.
  // Grants are gated by RSTn so nothing is accepted while reset is held.
  always_comb begin
    GNT0  = 1'b0;
    GNT1  = 1'b0;
    ptr_d = ptr_q;
    if (RSTn) begin
      if (REQ0 && (!REQ1 || ptr_q)) begin
        GNT0 = 1'b1;
      end else if (REQ1) begin
        GNT1 = 1'b1;
      end
    end
    if (GNT0) begin
      ptr_d = 1'b0;
    end else if (GNT1) begin
      ptr_d = 1'b1;
    end
  end

  // Stage 1 captures the granted command. Address and data hold when idle.
  always_comb begin
    s1Valid_d = GNT0 | GNT1;
    s1Owner_d = GNT1;
    s1We_d    = '0;
    s1A_d     = s1A_q;
    s1Di_d    = s1Di_q;
    if (GNT0) begin
      s1We_d = WE0;
      s1A_d  = A0;
      s1Di_d = DI0;
    end else if (GNT1) begin
      s1We_d = WE1;
      s1A_d  = A1;
      s1Di_d = DI1;
    end
  end

  always_comb begin
    rdAck0 = s2Valid_q && !s2Owner_q && s2Read_q;
    rdAck1 = s2Valid_q &&  s2Owner_q && s2Read_q;
    do0_d  = rdAck0 ? RAM_DO : do0_q;
    do1_d  = rdAck1 ? RAM_DO : do1_q;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ptr_q     <= 1'b1;
      s1Valid_q <= 1'b0;
      s1Owner_q <= 1'b0;
      s1We_q    <= '0;
      s1A_q     <= '0;
      s1Di_q    <= '0;
      s2Valid_q <= 1'b0;
      s2Owner_q <= 1'b0;
      s2Read_q  <= 1'b0;
      do0_q     <= '0;
      do1_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      s1Valid_q <= s1Valid_d;
      s1Owner_q <= s1Owner_d;
      s1We_q    <= s1We_d;
      s1A_q     <= s1A_d;
      s1Di_q    <= s1Di_d;
      s2Valid_q <= s1Valid_q;
      s2Owner_q <= s1Owner_q;
      s2Read_q  <= (s1We_q == '0);
      do0_q     <= do0_d;
      do1_q     <= do1_d;
    end
  end

  assign RAM_EN = s1Valid_q;
  assign RAM_WE = s1We_q;
  assign RAM_A  = s1A_q;
  assign RAM_DI = s1Di_q;
  assign ACK0   = s2Valid_q && !s2Owner_q;
  assign ACK1   = s2Valid_q &&  s2Owner_q;
  // Read data passes straight through on a read ACK; otherwise the last read value is held.
  assign DO0    = do0_d;
  assign DO1    = do1_d;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter with a behavioural 128x32 RAM model (read-first, 1-cycle read).
// Inputs are driven on the falling edge, and outputs are checked 1 ns later.
module tb_dffram_arbiter;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [3:0]  WE0 = '0, WE1 = '0;
  logic [6:0]  A0 = '0, A1 = '0;
  logic [31:0] DI0 = '0, DI1 = '0;
  logic        GNT0, GNT1, ACK0, ACK1;
  logic [31:0] DO0, DO1;
  logic        RAM_EN;
  logic [3:0]  RAM_WE;
  logic [6:0]  RAM_A;
  logic [31:0] RAM_DI;
  logic [31:0] RAM_DO;
  logic [31:0] mem [0:127];
  int checks = 0;
  int errors = 0;

  dffram_arbiter #(.AW(7), .DW(32), .WSIZE(4)) dut (
    .CLK(CLK), .RSTn(RSTn), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .A0(A0), .A1(A1), .DI0(DI0), .DI1(DI1), .GNT0(GNT0), .GNT1(GNT1),
    .ACK0(ACK0), .ACK1(ACK1), .DO0(DO0), .DO1(DO1), .RAM_EN(RAM_EN),
    .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_EN) begin
      for (int b = 0; b < 4; b++)
        if (RAM_WE[b]) mem[RAM_A][8*b +: 8] <= RAM_DI[8*b +: 8];
      RAM_DO <= mem[RAM_A];
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RSTn = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 4'hF; A0 = 7'h3; DI0 = 32'h1;
    step(); #1;
    checks++;
    if ({GNT0, GNT1, ACK0, ACK1, RAM_EN} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl got %b want 00000", {GNT0, GNT1, ACK0, ACK1, RAM_EN});
    end
    checks++;
    if ({RAM_WE, RAM_A, RAM_DI, DO0, DO1} !== '0) begin
      errors++; $display("[TB] FAIL reset_data got we=%h a=%h di=%h do0=%h do1=%h want 0",
                         RAM_WE, RAM_A, RAM_DI, DO0, DO1);
    end
    step();
    REQ0 = 1'b0; REQ1 = 1'b0; WE0 = '0; RSTn = 1'b1;
  endtask

  task automatic test_write_read();
    step(); REQ0 = 1'b1; WE0 = 4'hF; A0 = 7'h05; DI0 = 32'hDEADBEEF; #1;
    checks++;
    if (GNT0 !== 1'b1) begin errors++; $display("[TB] FAIL wr_gnt0 got %b want 1", GNT0); end
    step(); WE0 = 4'h0; #1;
    checks++;
    if (GNT0 !== 1'b1) begin errors++; $display("[TB] FAIL rd_gnt0 got %b want 1", GNT0); end
    checks++;
    if ({RAM_EN, RAM_WE, RAM_A, RAM_DI} !== {1'b1, 4'hF, 7'h05, 32'hDEADBEEF}) begin
      errors++; $display("[TB] FAIL wr_stage1 got en=%b we=%h a=%h di=%h want 1 f 05 deadbeef",
                         RAM_EN, RAM_WE, RAM_A, RAM_DI);
    end
    step(); REQ0 = 1'b0; #1;
    checks++;
    if ({ACK0, ACK1} !== 2'b10) begin errors++; $display("[TB] FAIL wr_ack got %b want 10", {ACK0, ACK1}); end
    step(); #1;
    checks++;
    if (ACK0 !== 1'b1 || DO0 !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL rd_ack got ack=%b do0=%h want 1 deadbeef", ACK0, DO0);
    end
    step(); #1;
    checks++;
    if (ACK0 !== 1'b0 || DO0 !== 32'hDEADBEEF || RAM_EN !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_hold got ack=%b do0=%h en=%b want 0 deadbeef 0", ACK0, DO0, RAM_EN);
    end
  endtask

  task automatic test_conflict();
    step(); RSTn = 1'b0;
    step(); RSTn = 1'b1;
    WE0 = '0; WE1 = '0; A0 = 7'h10; A1 = 7'h11;
    for (int i = 0; i < 6; i++) begin
      REQ0 = (i < 4); REQ1 = (i < 4); #1;
      if (i < 4) begin
        checks++;
        if ({GNT0, GNT1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("[TB] FAIL conflict_gnt[%0d] got %b want %b", i, {GNT0, GNT1},
                             (i % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      checks++;
      if ({ACK0, ACK1} !== ((i < 2) ? 2'b00 : (i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("[TB] FAIL conflict_ack[%0d] got %b want %b", i, {ACK0, ACK1},
                           (i < 2) ? 2'b00 : (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      step();
    end
  endtask

  task automatic test_partial();
    REQ0 = 1'b1; WE0 = 4'hF; A0 = 7'h7F; DI0 = 32'h11223344;
    step(); WE0 = 4'h2; DI0 = 32'hAABBCCDD;
    step(); WE0 = 4'h0;
    step(); REQ0 = 1'b0; #1;
    checks++;
    if (ACK0 !== 1'b1) begin errors++; $display("[TB] FAIL partial_wr_ack got %b want 1", ACK0); end
    step(); #1;
    checks++;
    if (ACK0 !== 1'b1 || DO0 !== 32'h1122CC44) begin
      errors++; $display("[TB] FAIL partial_rd got ack=%b do0=%h want 1 1122cc44", ACK0, DO0);
    end
    step(); #1;
    checks++;
    if (ACK0 !== 1'b0 || DO0 !== 32'h1122CC44) begin
      errors++; $display("[TB] FAIL partial_hold got ack=%b do0=%h want 0 1122cc44", ACK0, DO0);
    end
  endtask

  task automatic test_back_to_back();
    int ackCount = 0;
    WE1 = '0;
    for (int i = 0; i < 130; i++) begin
      step();
      REQ1 = (i < 128); A1 = 7'(i); #1;
      if (i < 128) begin
        checks++;
        if (GNT1 !== 1'b1) begin errors++; $display("[TB] FAIL stream_gnt1[%0d] got %b want 1", i, GNT1); end
      end
      if (i >= 1 && i <= 128) begin
        checks++;
        if (RAM_EN !== 1'b1 || RAM_A !== 7'(i - 1)) begin
          errors++; $display("[TB] FAIL stream_addr[%0d] got en=%b a=%h want 1 %h", i, RAM_EN, RAM_A, 7'(i - 1));
        end
      end
      if (ACK1) ackCount++;
      if (i == 7) begin
        checks++;
        if (ACK1 !== 1'b1 || DO1 !== 32'hDEADBEEF) begin
          errors++; $display("[TB] FAIL stream_do_05 got ack=%b do1=%h want 1 deadbeef", ACK1, DO1);
        end
      end
      if (i == 129) begin
        checks++;
        if (ACK1 !== 1'b1 || DO1 !== 32'h1122CC44) begin
          errors++; $display("[TB] FAIL stream_do_7f got ack=%b do1=%h want 1 1122cc44", ACK1, DO1);
        end
      end
    end
    step(); #1;
    if (ACK1) ackCount++;
    checks++;
    if (ackCount != 128) begin errors++; $display("[TB] FAIL stream_ack_count got %0d want 128", ackCount); end
  endtask

  task automatic test_raw_cross();
    step(); REQ0 = 1'b1; WE0 = 4'hF; A0 = 7'h0A; DI0 = 32'h12345678;
    step(); REQ0 = 1'b0; WE0 = '0; REQ1 = 1'b1; WE1 = '0; A1 = 7'h0A; #1;
    checks++;
    if (GNT1 !== 1'b1) begin errors++; $display("[TB] FAIL raw_gnt1 got %b want 1", GNT1); end
    step(); REQ1 = 1'b0; #1;
    checks++;
    if ({ACK0, ACK1} !== 2'b10) begin errors++; $display("[TB] FAIL raw_wr_ack got %b want 10", {ACK0, ACK1}); end
    step(); #1;
    checks++;
    if (ACK1 !== 1'b1 || DO1 !== 32'h12345678) begin
      errors++; $display("[TB] FAIL raw_rd got ack=%b do1=%h want 1 12345678", ACK1, DO1);
    end
  endtask

  task automatic test_reset_mid();
    step(); REQ0 = 1'b1; WE0 = 4'hF; A0 = 7'h20; DI0 = 32'hCAFEF00D; #1;
    checks++;
    if (GNT0 !== 1'b1) begin errors++; $display("[TB] FAIL mid_gnt0 got %b want 1", GNT0); end
    step(); RSTn = 1'b0; REQ0 = 1'b0; WE0 = '0; #1;
    checks++;
    if ({GNT0, GNT1, ACK0, ACK1, RAM_EN, RAM_WE, RAM_A, RAM_DI, DO0, DO1} !== '0) begin
      errors++; $display("[TB] FAIL mid_reset_outputs got gnt=%b ack=%b en=%b we=%h a=%h di=%h do0=%h do1=%h want 0",
                         {GNT0, GNT1}, {ACK0, ACK1}, RAM_EN, RAM_WE, RAM_A, RAM_DI, DO0, DO1);
    end
    step(); RSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({ACK0, ACK1} !== 2'b00) begin
        errors++; $display("[TB] FAIL mid_no_ack[%0d] got %b want 00", i, {ACK0, ACK1});
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_partial();
    test_back_to_back();
    test_raw_cross();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
